// File: rtl/pdp8_tty_pkg.sv
// Shared definitions for the PDP-8 teletype serial pair (M706 receiver and
// M707 transmitter).
//   tty_state_t        : frame sequencer state encoding
//   DEF_CLKS_PER_BIT   : default clock cycles per serial bit time
//   DEF_DATA_BITS      : default data bits per character
//   DEF_STOP_BITS      : default stop bits per frame
//   MARK               : idle / stop level of the current loop line
package pdp8_tty_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tty_state_t;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;
  localparam int DEF_STOP_BITS    = 2;

  localparam logic MARK = 1'b1;

endpackage

// File: rtl/tty_bit_timer.sv
// Bit-time divider shared by the teletype receiver and transmitter.
// Counts enabled clock cycles and pulses bit_end for one cycle on the last
// cycle of every bit time.
//   clk      : system clock
//   rst      : synchronous active-high reset, counter to 0
//   clear    : synchronous restart of the bit time, counter to 0
//   enable   : count this cycle
//   bit_end  : high on the final cycle of a bit time (counter wraps on this edge)
module tty_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] clk_cnt_q;
  logic [CNT_W-1:0] clk_cnt_d;

  // A clear always restarts the bit time, even if the count is also enabled.
  assign bit_end = enable && !clear && (clk_cnt_q == LAST);

  always_comb begin
    clk_cnt_d = clk_cnt_q;
    if (clear) begin
      clk_cnt_d = '0;
    end else if (enable) begin
      clk_cnt_d = (clk_cnt_q == LAST) ? '0 : clk_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt_q <= '0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
    end
  end

endmodule

// File: rtl/m707_tty_xmit.sv
// M707 teletype transmitter. Latches a character from the AC bus on a TLS
// load strobe and sends it LSB-first as start bit, data bits and stop bits,
// then raises the printer flag.
//   clk         : system clock
//   rst         : synchronous active-high reset (I/O power clear)
//   load        : 1-cycle TLS strobe, accepted only while not busy
//   data_in     : character to send, sampled on an accepted load
//   clear_flag  : 1-cycle strobe that clears the done flag
//   serial_out  : registered line output, 1 = mark, 0 = space
//   flag        : transmitter done flag, held until cleared
//   busy        : frame in progress
module m707_tty_xmit
  import pdp8_tty_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int STOP_BITS    = DEF_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 clear_flag,
  output logic                 serial_out,
  output logic                 flag,
  output logic                 busy
);

  localparam int BIT_W = $clog2(DATA_BITS + STOP_BITS + 1);

  tty_state_t           state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 serial_q, serial_d;
  logic                 flag_q, flag_d;
  logic                 busy_q, busy_d;

  logic load_accept;
  logic bit_end;
  logic last_data;
  logic last_stop;
  logic frame_done;

  assign load_accept = load && (state_q == IDLE);
  assign last_data   = (bit_cnt_q == BIT_W'(DATA_BITS - 1));
  assign last_stop   = (bit_cnt_q == BIT_W'(STOP_BITS - 1));
  assign frame_done  = (state_q == STOP) && bit_end && last_stop;

  // The timer only runs during a frame; an accepted load restarts it so the
  // start bit gets a full bit time.
  tty_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (load_accept),
    .enable (busy_q),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      serial_q  <= MARK;
      flag_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      serial_q  <= serial_d;
      flag_q    <= flag_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_accept)            state_d = START;
      START:   if (bit_end)                state_d = DATA;
      DATA:    if (bit_end && last_data)   state_d = STOP;
      STOP:    if (bit_end && last_stop)   state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // The line is registered one bit ahead: on each bit_end edge the value of
  // the next bit is loaded, so the shift register always holds the bits that
  // have not yet been put on the line.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    serial_d  = serial_q;
    busy_d    = busy_q;
    flag_d    = flag_q;
    case (state_q)
      IDLE: begin
        if (load_accept) begin
          shift_d   = data_in;
          bit_cnt_d = '0;
          serial_d  = ~MARK;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          serial_d  = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (last_data) begin
            serial_d  = MARK;
            bit_cnt_d = '0;
          end else begin
            serial_d  = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            busy_d    = 1'b0;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: begin
        serial_d = MARK;
        busy_d   = 1'b0;
      end
    endcase
    // Completion is applied after the clears so a coincident clear_flag
    // cannot swallow a finished frame.
    if (clear_flag || load_accept) flag_d = 1'b0;
    if (frame_done)                flag_d = 1'b1;
  end

  assign serial_out = serial_q;
  assign flag       = flag_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_m707_tty_xmit.sv
// Directed bench for the M707 teletype transmitter at default parameters
// (16 clocks per bit, 8 data bits, 2 stop bits, 176-cycle frame).
// Inputs change and outputs are sampled on the falling edge; sample index m
// means "just after rising edge N+m", where N is the edge that took the load.
module tb_m707_tty_xmit;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] data_in;
  logic       clear_flag;
  logic       serial_out;
  logic       flag;
  logic       busy;

  int checks;
  int errors;

  m707_tty_xmit dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data_in   (data_in),
    .clear_flag(clear_flag),
    .serial_out(serial_out),
    .flag      (flag),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one full clock: through the rising edge to the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset, then 50 idle cycles with the line at mark and nothing set.
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      checks++;
      if (serial_out !== 1'b1 || flag !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_idle cycle=%0d got line=%b flag=%b busy=%b want 1 0 0",
                 i, serial_out, flag, busy);
      end
      step();
    end
  endtask

  // Frame 8'hC1: bit times 0,1,0,0,0,0,0,1,1,1,1 then flag at N+176.
  task automatic test_single_frame();
    logic [10:0] exp_line;
    exp_line = 11'b111_1000_0010;
    data_in  = 8'hC1;
    load     = 1'b1;
    step();
    load    = 1'b0;
    data_in = 8'h00;
    for (int m = 0; m < 176; m++) begin
      checks++;
      if (serial_out !== exp_line[m/16]) begin
        errors++;
        $display("[TB] FAIL c1_line m=%0d got %b want %b", m, serial_out, exp_line[m/16]);
      end
      checks++;
      if (busy !== 1'b1 || flag !== 1'b0) begin
        errors++;
        $display("[TB] FAIL c1_status m=%0d got busy=%b flag=%b want 1 0", m, busy, flag);
      end
      step();
    end
    checks++;
    if (busy !== 1'b0 || flag !== 1'b1 || serial_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL c1_done got busy=%b flag=%b line=%b want 0 1 1", busy, flag, serial_out);
    end
  endtask

  // A load of 8'h55 at N+100 must not disturb the 8'hC1 frame or its timing.
  task automatic test_load_while_busy();
    logic [10:0] exp_line;
    exp_line = 11'b111_1000_0010;
    data_in  = 8'hC1;
    load     = 1'b1;
    step();
    load    = 1'b0;
    data_in = 8'h00;
    for (int m = 0; m < 176; m++) begin
      if (m == 100) begin
        load    = 1'b0;
        data_in = 8'h00;
      end
      checks++;
      if (serial_out !== exp_line[m/16]) begin
        errors++;
        $display("[TB] FAIL busy_load_line m=%0d got %b want %b", m, serial_out, exp_line[m/16]);
      end
      checks++;
      if (busy !== 1'b1 || flag !== 1'b0) begin
        errors++;
        $display("[TB] FAIL busy_load_status m=%0d got busy=%b flag=%b want 1 0", m, busy, flag);
      end
      if (m == 99) begin
        load    = 1'b1;
        data_in = 8'h55;
      end
      step();
    end
    checks++;
    if (busy !== 1'b0 || flag !== 1'b1 || serial_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_load_done got busy=%b flag=%b line=%b want 0 1 1",
               busy, flag, serial_out);
    end
  endtask

  // Frame 8'h00, then 8'hFF loaded on the first cycle busy reads 0.
  task automatic test_back_to_back();
    logic [10:0] exp_zero;
    logic [10:0] exp_ones;
    exp_zero = 11'b110_0000_0000;
    exp_ones = 11'b111_1111_1110;
    data_in  = 8'h00;
    load     = 1'b1;
    step();
    load = 1'b0;
    for (int m = 0; m < 176; m++) begin
      checks++;
      if (serial_out !== exp_zero[m/16]) begin
        errors++;
        $display("[TB] FAIL b2b_00_line m=%0d got %b want %b", m, serial_out, exp_zero[m/16]);
      end
      step();
    end
    checks++;
    if (busy !== 1'b0 || flag !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_00_done got busy=%b flag=%b want 0 1", busy, flag);
    end
    data_in = 8'hFF;
    load    = 1'b1;
    step();
    load    = 1'b0;
    data_in = 8'h00;
    for (int m = 0; m < 176; m++) begin
      checks++;
      if (serial_out !== exp_ones[m/16]) begin
        errors++;
        $display("[TB] FAIL b2b_ff_line m=%0d got %b want %b", m, serial_out, exp_ones[m/16]);
      end
      checks++;
      if (busy !== 1'b1 || flag !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_ff_status m=%0d got busy=%b flag=%b want 1 0", m, busy, flag);
      end
      step();
    end
    checks++;
    if (busy !== 1'b0 || flag !== 1'b1 || serial_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_ff_done got busy=%b flag=%b line=%b want 0 1 1", busy, flag, serial_out);
    end
  endtask

  // clear_flag on the completion edge loses to the set; one cycle later it clears.
  task automatic test_clear_flag();
    data_in = 8'h3C;
    load    = 1'b1;
    step();
    load = 1'b0;
    for (int m = 0; m < 175; m++) step();
    checks++;
    if (busy !== 1'b1 || flag !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_pre got busy=%b flag=%b want 1 0", busy, flag);
    end
    clear_flag = 1'b1;
    step();
    checks++;
    if (flag !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_on_done got flag=%b busy=%b want 1 0", flag, busy);
    end
    step();
    clear_flag = 1'b0;
    checks++;
    if (flag !== 1'b0 || busy !== 1'b0 || serial_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clr_after got flag=%b busy=%b line=%b want 0 0 1", flag, busy, serial_out);
    end
  endtask

  // Reset at N+60 aborts the frame; a following 8'hA5 frame is complete.
  task automatic test_reset_midframe();
    logic [10:0] exp_line;
    exp_line = 11'b111_0100_1010;
    data_in  = 8'h0F;
    load     = 1'b1;
    step();
    load = 1'b0;
    for (int m = 0; m < 59; m++) step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_mid_pre got busy=%b want 1", busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (serial_out !== 1'b1 || busy !== 1'b0 || flag !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid got line=%b busy=%b flag=%b want 1 0 0", serial_out, busy, flag);
    end
    step();
    step();
    data_in = 8'hA5;
    load    = 1'b1;
    step();
    load    = 1'b0;
    data_in = 8'h00;
    for (int m = 0; m < 176; m++) begin
      checks++;
      if (serial_out !== exp_line[m/16]) begin
        errors++;
        $display("[TB] FAIL rst_a5_line m=%0d got %b want %b", m, serial_out, exp_line[m/16]);
      end
      step();
    end
    checks++;
    if (busy !== 1'b0 || flag !== 1'b1 || serial_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_a5_done got busy=%b flag=%b line=%b want 0 1 1", busy, flag, serial_out);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    load       = 1'b0;
    data_in    = 8'h00;
    clear_flag = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_load_while_busy();
    test_back_to_back();
    test_clear_flag();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
